ex: RTL

//  Execute stage; consumes the ID/EX pipeline register outputs and feeds EX/MEM.

---
 rtl/ex.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ex.sv
// Execute stage: combinational logic/shift/arith result path plus an iterative
// restoring DIV/DIVU unit (compiled in only when EXE_DIV_EN is defined).
module ex #(
  parameter int STEPS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        div_cancel_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic        is_div;
  logic        sub_op;
  logic        ov;
  logic [31:0] sum;
  logic [31:0] result;

  assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);

  always_comb begin
    sub_op = (aluop_i == OP_SUB) || (aluop_i == OP_SUBU);
    sum    = sub_op ? (reg1_i - reg2_i) : (reg1_i + reg2_i);
    ov     = 1'b0;
    result = 32'd0;
    // Signed overflow only matters for the trapping forms; the U forms wrap silently.
    if (aluop_i == OP_ADD)
      ov = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    else if (aluop_i == OP_SUB)
      ov = (reg1_i[31] != reg2_i[31]) && (sum[31] != reg1_i[31]);
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  result = reg1_i & reg2_i;
          OP_OR:   result = reg1_i | reg2_i;
          OP_XOR:  result = reg1_i ^ reg2_i;
          OP_NOR:  result = ~(reg1_i | reg2_i);
          default: result = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result = reg1_i << reg2_i[4:0];
          OP_SRL:  result = reg1_i >> reg2_i[4:0];
          OP_SRA:  result = $signed(reg1_i) >>> reg2_i[4:0];
          default: result = 32'd0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: result = sum;
          OP_SLT:  result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
          OP_SLTU: result = {31'd0, reg1_i < reg2_i};
          default: result = 32'd0;
        endcase
      end
      default: result = 32'd0;
    endcase
  end

  assign wd_o    = rst ? 5'd0 : wd_i;
  assign wreg_o  = (rst || is_div || ov) ? 1'b0 : wreg_i;
  assign wdata_o = (rst || is_div) ? 32'd0 : result;

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  localparam logic [5:0] LAST = 6'(32 / STEPS - 1);

  div_state_t  state;
  logic [5:0]  cnt;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] trial;
  logic [31:0] rem_n;
  logic [31:0] quo_n;
  logic [31:0] hi_fin;
  logic [31:0] lo_fin;

  assign sgn   = (aluop_i == OP_DIV);
  assign mag_a = (sgn && reg1_i[31]) ? -reg1_i : reg1_i;
  assign mag_b = (sgn && reg2_i[31]) ? -reg2_i : reg2_i;

  // quo starts as the dividend and is shifted out MSB-first into rem while
  // quotient bits are shifted in at the bottom.
  always_comb begin
    rem_n = rem;
    quo_n = quo;
    trial = 33'd0;
    for (int i = 0; i < STEPS; i++) begin
      trial = {rem_n, quo_n[31]};
      quo_n = {quo_n[30:0], 1'b0};
      if (trial >= {1'b0, divisor}) begin
        trial    = trial - {1'b0, divisor};
        quo_n[0] = 1'b1;
      end
      rem_n = trial[31:0];
    end
    lo_fin = neg_q ? -quo_n : quo_n;
    hi_fin = neg_r ? -rem_n : rem_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      divisor <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (div_cancel_i) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            divisor <= mag_b;
            quo     <= mag_a;
            rem     <= 32'd0;
            cnt     <= 6'd0;
            neg_q   <= sgn && (reg1_i[31] ^ reg2_i[31]);
            neg_r   <= sgn && reg1_i[31];
            if (reg2_i == 32'd0) begin
              hi_q  <= reg1_i;
              lo_q  <= 32'hFFFF_FFFF;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            hi_q  <= hi_fin;
            lo_q  <= lo_fin;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stallreq_o = !rst && !div_cancel_i &&
                      (((state == IDLE) && is_div) || (state == BUSY));
  assign whilo_o    = !rst && !div_cancel_i && (state == DONE);
  assign hi_o       = rst ? 32'd0 : hi_q;
  assign lo_o       = rst ? 32'd0 : lo_q;
`else
  logic unused_div_inputs;
  assign unused_div_inputs = &{1'b0, clk, div_cancel_i};

  assign stallreq_o = 1'b0;
  assign whilo_o    = 1'b0;
  assign hi_o       = 32'd0;
  assign lo_o       = 32'd0;
`endif

endmodule
